// File: rtl/serial_parity_pkg.sv
// rtl/serial_parity_pkg.sv - shared state encoding and parity-sense constants for the serial parity link
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    PAR   = 2'd3
  } state_t;

  // Parity sense shared with the serial parity checker on the receive side.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_tx.sv
// rtl/serial_parity_tx.sv - LSB-first serial transmitter with trailing parity bit; optional start bit via SERIAL_PARITY_TX_START_BIT_EN
module serial_parity_tx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              tx_last
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic PAR_SEED = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  state_t            state, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              tx_bit_d, tx_active_d, tx_last_d;
  logic              accept;

  // Gated by rst_n so upstream never sees ready while the block is held in reset.
  assign din_ready = rst_n && ((state == IDLE) || (state == PAR));
  assign accept    = din_valid && din_ready;

  // Outputs are registered from the next-state view, so tx_* always describe the current state.
  always_comb begin
    state_d     = state;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    tx_bit_d    = 1'b0;
    tx_active_d = 1'b0;
    tx_last_d   = 1'b0;

    case (state)
      IDLE, PAR: begin
        if (accept) begin
          par_d       = PAR_SEED ^ (^din);
          cnt_d       = '0;
          tx_active_d = 1'b1;
`ifdef SERIAL_PARITY_TX_START_BIT_EN
          state_d     = START;
          shift_d     = din;
          tx_bit_d    = 1'b1;
`else
          state_d     = DATA;
          shift_d     = din >> 1;
          tx_bit_d    = din[0];
`endif
        end else begin
          state_d = IDLE;
        end
      end

`ifdef SERIAL_PARITY_TX_START_BIT_EN
      START: begin
        state_d     = DATA;
        tx_bit_d    = shift_q[0];
        shift_d     = shift_q >> 1;
        tx_active_d = 1'b1;
      end
`endif

      DATA: begin
        tx_active_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d   = PAR;
          tx_bit_d  = par_q;
          tx_last_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          tx_bit_d = shift_q[0];
          shift_d  = shift_q >> 1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      tx_bit    <= 1'b0;
      tx_active <= 1'b0;
      tx_last   <= 1'b0;
    end else begin
      state     <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      tx_bit    <= tx_bit_d;
      tx_active <= tx_active_d;
      tx_last   <= tx_last_d;
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// tb/tb_serial_parity_tx.sv - scoreboard bench driving an even-parity and an odd-parity transmitter in lockstep
module tb_serial_parity_tx;

`ifdef SERIAL_PARITY_TX_START_BIT_EN
  localparam int START_LEN = 1;
`else
  localparam int START_LEN = 0;
`endif
  localparam int FRAME_LEN = START_LEN + 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       rdy_e, bit_e, act_e, last_e;
  logic       rdy_o, bit_o, act_o, last_o;

  int vectors = 0;
  int miscompares = 0;

  logic [33:0] q_even[$];
  logic [33:0] q_odd[$];

  int last_run = 0;
  int run = 0;

  always #5 clk = ~clk;

  serial_parity_tx #(.DATA_W(8), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_e), .tx_bit(bit_e), .tx_active(act_e), .tx_last(last_e)
  );

  serial_parity_tx #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_o), .tx_bit(bit_o), .tx_active(act_o), .tx_last(last_o)
  );

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [33:0] mk(input logic [7:0] d, input logic p);
    logic [33:0] v;
    v = '0;
    if (START_LEN == 1) v[0] = 1'b1;
    v[START_LEN +: 8] = d;
    v[START_LEN + 8]  = p;
    return v;
  endfunction

  // Monitor for the even-parity instance; also tracks runs of consecutive active cycles.
  logic [33:0] got_e;
  int          n_e = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      n_e = 0; got_e = '0; run = 0;
    end else begin
      if (act_e) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (act_e) begin
        if (n_e == 0) got_e = '0;
        if (n_e < 34) got_e[n_e] = bit_e;
        n_e++;
        if (last_e) begin
          if (q_even.size() == 0) check("even_unexpected_frame", got_e, 34'h0);
          else begin
            check("even_frame_len", n_e, FRAME_LEN);
            check("even_frame_bits", got_e, q_even.pop_front());
          end
          n_e = 0;
        end
      end
    end
  end

  logic [33:0] got_o;
  int          n_o = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      n_o = 0; got_o = '0;
    end else if (act_o) begin
      if (n_o == 0) got_o = '0;
      if (n_o < 34) got_o[n_o] = bit_o;
      n_o++;
      if (last_o) begin
        if (q_odd.size() == 0) check("odd_unexpected_frame", got_o, 34'h0);
        else begin
          check("odd_frame_len", n_o, FRAME_LEN);
          check("odd_frame_bits", got_o, q_odd.pop_front());
        end
        n_o = 0;
      end
    end
  end

  // Presents a word and holds it until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic po, input bit expect_frame);
    int n;
    din = d;
    din_valid = 1'b1;
    if (expect_frame) begin
      q_even.push_back(mk(d, pe));
      q_odd.push_back(mk(d, po));
    end
    n = 0;
    while (!(rdy_e && rdy_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: din_ready low for %0d cycles, required 1", n);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (act_e && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: tx_active still 1 after %0d cycles, required 0", n);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    din = 8'h00;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_even", {rdy_e, bit_e, act_e, last_e}, 4'b0000);
    check("reset_outputs_odd", {rdy_o, bit_o, act_o, last_o}, 4'b0000);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {rdy_e, rdy_o}, 2'b11);
    @(negedge clk);

    // Hand-computed parity: A5 four ones, 07 three, 00 none, 01/80 one, FF eight, C3 four.
    send(8'hA5, 1'b0, 1'b1, 1'b1);
    din_valid = 1'b0;
    wait_idle();
    send(8'h07, 1'b1, 1'b0, 1'b1);
    din_valid = 1'b0;
    wait_idle();
    send(8'h00, 1'b0, 1'b1, 1'b1);
    din_valid = 1'b0;
    wait_idle();

    send(8'h01, 1'b1, 1'b0, 1'b1);
    send(8'h80, 1'b1, 1'b0, 1'b1);
    din_valid = 1'b0;
    wait_idle();
    check("back_to_back_run", last_run, 2 * FRAME_LEN);

    send(8'hA5, 1'b0, 1'b1, 1'b1);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    din = 8'hFF;
    din_valid = 1'b1;
    check("ready_low_in_data", {rdy_e, rdy_o}, 2'b00);
    send(8'hFF, 1'b0, 1'b1, 1'b1);
    din_valid = 1'b0;
    wait_idle();
    check("held_word_gapless_run", last_run, 2 * FRAME_LEN);

    send(8'h3C, 1'b0, 1'b1, 1'b0);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("active_before_reset", act_e, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_even", {rdy_e, bit_e, act_e, last_e}, 4'b0000);
    check("async_reset_odd", {rdy_o, bit_o, act_o, last_o}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_mid_reset", {rdy_e, rdy_o}, 2'b11);
    @(negedge clk);
    send(8'hC3, 1'b0, 1'b1, 1'b1);
    din_valid = 1'b0;
    wait_idle();

    n = 0;
    while ((q_even.size() != 0 || q_odd.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("even_queue_drained", q_even.size(), 0);
    check("odd_queue_drained", q_odd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
